bm_dag3_stim_misr: RTL and testbench

BM_DAG3_STIM_MISR -- requirements
Module: bm_dag3_stim_misr

---
 rtl/bm_dag3_pkg.sv | 24 ++
 rtl/bm_dag3_lfsr8.sv | 42 ++++
 rtl/bm_dag3_stim_misr.sv | 142 ++++++++++++++
 tb/tb_bm_dag3_stim_misr.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bm_dag3_pkg.sv
// Shared constants for the DAG stimulus/MISR block.
//   state_e  : controller state encoding (IDLE, RUN, DRAIN, DONE)
//   LfsrSeed : value loaded into the stimulus LFSR on reset and on run start
//   LfsrTaps : feedback taps of the stimulus LFSR (b7^b5^b4^b3)
//   MisrTaps : feedback taps of the response MISR (b7^b5^b4^b3)
//   fib_step : one shift-left Fibonacci step; the new bit0 is the XOR of the tapped bits
package bm_dag3_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [7:0] LfsrSeed = 8'h01;
  localparam logic [7:0] LfsrTaps = 8'hB8;
  localparam logic [7:0] MisrTaps = 8'hB8;

  function automatic logic [7:0] fib_step(input logic [7:0] value, input logic [7:0] taps);
    return {value[6:0], ^(value & taps)};
  endfunction

endpackage

// File: rtl/bm_dag3_lfsr8.sv
// 8-bit Fibonacci stimulus LFSR.
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset, loads LfsrSeed
//   enable : advance one step this cycle
//   load   : reload LfsrSeed this cycle (takes priority over enable)
//   value  : low OutW bits of the current LFSR state
module bm_dag3_lfsr8
  import bm_dag3_pkg::*;
#(
  parameter int unsigned OutW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            load,
  output logic [OutW-1:0] value
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = LfsrSeed;
    end else if (enable) begin
      value_d = fib_step(value_q, LfsrTaps);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= LfsrSeed;
    end else begin
      value_q <= value_d;
    end
  end

  // Only the bits that feed stimulus leave the module; the rest stay internal feedback.
  assign value = value_q[OutW-1:0];

endmodule

// File: rtl/bm_dag3_stim_misr.sv
// Built-in self-test controller for a small DAG: drives LFSR stimulus for run_len cycles,
// then keeps compacting responses into an 8-bit MISR for DRAIN_CYC more cycles.
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset
//   start     : launch a run (honoured only in IDLE or DONE)
//   run_len   : number of stimulus vectors, latched when start is accepted
//   first     : stimulus operand A  (LFSR bits [BITS-1:0])
//   sceond    : stimulus operand B  (LFSR bits [2*BITS-1:BITS])
//   third     : stimulus bit C      (LFSR bit 2*BITS)
//   fourth    : stimulus bit D      (LFSR bit 2*BITS+1)
//   out0_in   : response vector from the DAG
//   out1_in   : response bit from the DAG
//   busy      : high in RUN and DRAIN
//   done      : high in DONE
//   signature : MISR contents, frozen in DONE
// Assumes 1 <= BITS <= 3 (stimulus fits in the LFSR) and DRAIN_CYC >= 1.
module bm_dag3_stim_misr
  import bm_dag3_pkg::*;
#(
  parameter int unsigned BITS      = 2,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      run_len,
  output logic [BITS-1:0] first,
  output logic [BITS-1:0] sceond,
  output logic            third,
  output logic            fourth,
  input  logic [BITS-1:0] out0_in,
  input  logic            out1_in,
  output logic            busy,
  output logic            done,
  output logic [7:0]      signature
);

  localparam int unsigned StimW     = 2 * BITS + 2;
  localparam logic [7:0]  DrainLast = 8'(DRAIN_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] run_len_q, run_len_d;
  logic [7:0] vec_cnt_q, vec_cnt_d;
  logic [7:0] drain_cnt_q, drain_cnt_d;
  logic [7:0] sig_q, sig_d;
  logic [7:0] misr_inject;
  logic [7:0] misr_next;
  logic       lfsr_load;
  logic       lfsr_en;
  logic [StimW-1:0] lfsr_val;

  bm_dag3_lfsr8 #(
    .OutW (StimW)
  ) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (lfsr_en),
    .load   (lfsr_load),
    .value  (lfsr_val)
  );

  // Responses enter the MISR zero-extended as {out1_in, out0_in}.
  always_comb begin
    misr_inject = '0;
    misr_inject[BITS:0] = {out1_in, out0_in};
    misr_next = fib_step(sig_q, MisrTaps) ^ misr_inject;
  end

  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    vec_cnt_d   = vec_cnt_q;
    drain_cnt_d = drain_cnt_q;
    sig_d       = sig_q;
    lfsr_load   = 1'b0;
    lfsr_en     = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          lfsr_load   = 1'b1;
          run_len_d   = run_len;
          vec_cnt_d   = '0;
          drain_cnt_d = '0;
          sig_d       = '0;
          state_d     = (run_len != 8'd0) ? StRun : StDrain;
        end
      end
      StRun: begin
        lfsr_en   = 1'b1;
        sig_d     = misr_next;
        vec_cnt_d = vec_cnt_q + 8'd1;
        if (vec_cnt_q == run_len_q - 8'd1) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        sig_d       = misr_next;
        drain_cnt_d = drain_cnt_q + 8'd1;
        if (drain_cnt_q == DrainLast) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      run_len_q   <= '0;
      vec_cnt_q   <= '0;
      drain_cnt_q <= '0;
      sig_q       <= '0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      vec_cnt_q   <= vec_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      sig_q       <= sig_d;
    end
  end

  // Stimulus comes straight off the LFSR flops and is forced to zero outside RUN.
  always_comb begin
    first  = '0;
    sceond = '0;
    third  = 1'b0;
    fourth = 1'b0;
    if (state_q == StRun) begin
      first  = lfsr_val[BITS-1:0];
      sceond = lfsr_val[2*BITS-1:BITS];
      third  = lfsr_val[2*BITS];
      fourth = lfsr_val[2*BITS+1];
    end
  end

  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign signature = sig_q;

endmodule

// File: tb/tb_bm_dag3_stim_misr.sv
// Directed bench for bm_dag3_stim_misr: a per-cycle vector table followed by hand-written
// sequences for asynchronous reset, back-to-back runs and start ignored during DRAIN.
module tb_bm_dag3_stim_misr;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] run_len;
  logic [1:0] first;
  logic [1:0] sceond;
  logic       third;
  logic       fourth;
  logic [1:0] out0_in;
  logic       out1_in;
  logic       busy;
  logic       done;
  logic [7:0] signature;

  int pass_cnt  = 0;
  int check_cnt = 0;

  bm_dag3_stim_misr #(
    .BITS      (2),
    .DRAIN_CYC (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .run_len   (run_len),
    .first     (first),
    .sceond    (sceond),
    .third     (third),
    .fourth    (fourth),
    .out0_in   (out0_in),
    .out1_in   (out1_in),
    .busy      (busy),
    .done      (done),
    .signature (signature)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       st;
    logic [7:0] rl;
    logic [1:0] o0;
    logic       o1;
    logic [1:0] e_first;
    logic [1:0] e_sceond;
    logic       e_third;
    logic       e_fourth;
    logic       e_busy;
    logic       e_done;
    logic [7:0] e_sig;
  } vec_t;

  vec_t tbl[32];
  int   nrows = 0;

  task automatic row(input logic st, input logic [7:0] rl, input logic [1:0] o0,
                     input logic o1, input logic [1:0] ef, input logic [1:0] es,
                     input logic et, input logic efo, input logic eb, input logic ed,
                     input logic [7:0] esig);
    tbl[nrows] = '{st, rl, o0, o1, ef, es, et, efo, eb, ed, esig};
    nrows++;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] ef, input logic [1:0] es,
                               input logic et, input logic efo, input logic eb,
                               input logic ed, input logic [7:0] esig);
    check({tag, " first"}, 8'(first), 8'(ef));
    check({tag, " sceond"}, 8'(sceond), 8'(es));
    check({tag, " third"}, 8'(third), 8'(et));
    check({tag, " fourth"}, 8'(fourth), 8'(efo));
    check({tag, " busy"}, 8'(busy), 8'(eb));
    check({tag, " done"}, 8'(done), 8'(ed));
    check({tag, " signature"}, signature, esig);
  endtask

  initial begin
    int cyc;

    // Each row: inputs applied before a rising edge, outputs expected after it.
    // run_len=3, zero responses; run_len changes after start must not matter.
    row(1, 8'd3, 2'd0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 8'h00);  // RUN vec0 lfsr=01
    row(0, 8'd1, 2'd0, 0, 2'b10, 2'b00, 0, 0, 1, 0, 8'h00);  // RUN vec1 lfsr=02
    row(0, 8'd1, 2'd0, 0, 2'b00, 2'b01, 0, 0, 1, 0, 8'h00);  // RUN vec2 lfsr=04
    row(0, 8'd1, 2'd0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 8'h00);  // DRAIN0
    row(0, 8'd1, 2'd0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 8'h00);  // DRAIN1
    row(0, 8'd1, 2'd0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 8'h00);  // DRAIN2
    row(0, 8'd1, 2'd0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 8'h00);  // DRAIN3
    row(0, 8'd1, 2'd0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 8'h00);  // DONE (3+4 cycles)
    row(0, 8'd1, 2'd0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 8'h00);  // DONE holds
    // run_len=1, out0_in=01: MISR 01,03,07,0F,1E.
    row(1, 8'd1, 2'd1, 0, 2'b01, 2'b00, 0, 0, 1, 0, 8'h00);  // RUN, signature reseeded
    row(0, 8'd1, 2'd1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 8'h01);
    row(0, 8'd1, 2'd1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 8'h03);
    row(0, 8'd1, 2'd1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 8'h07);
    row(0, 8'd1, 2'd1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 8'h0F);
    row(0, 8'd1, 2'd1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 8'h1E);
    row(0, 8'd1, 2'd1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 8'h1E);  // frozen in DONE
    // run_len=0, out1_in=1: RUN skipped, 4 DRAIN updates 04,0C,1D,3E.
    row(1, 8'd0, 2'd0, 1, 2'b00, 2'b00, 0, 0, 1, 0, 8'h00);
    row(0, 8'd0, 2'd0, 1, 2'b00, 2'b00, 0, 0, 1, 0, 8'h04);
    row(0, 8'd0, 2'd0, 1, 2'b00, 2'b00, 0, 0, 1, 0, 8'h0C);
    row(0, 8'd0, 2'd0, 1, 2'b00, 2'b00, 0, 0, 1, 0, 8'h1D);
    row(0, 8'd0, 2'd0, 1, 2'b00, 2'b00, 0, 0, 0, 1, 8'h3E);

    reset   = 1'b1;
    start   = 1'b0;
    run_len = 8'd0;
    out0_in = 2'd0;
    out1_in = 1'b0;
    @(negedge clock);
    check_outputs("reset", 2'b00, 2'b00, 0, 0, 0, 0, 8'h00);
    reset = 1'b0;
    tick();
    check_outputs("idle", 2'b00, 2'b00, 0, 0, 0, 0, 8'h00);

    for (int i = 0; i < nrows; i++) begin
      start   = tbl[i].st;
      run_len = tbl[i].rl;
      out0_in = tbl[i].o0;
      out1_in = tbl[i].o1;
      tick();
      check_outputs($sformatf("row%0d", i), tbl[i].e_first, tbl[i].e_sceond, tbl[i].e_third,
                    tbl[i].e_fourth, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_sig);
    end

    // Reset in RUN cycle 2 with out0_in=11: signature 00 -> 03 -> 05, then cleared at once.
    start   = 1'b1;
    run_len = 8'd5;
    out0_in = 2'b11;
    out1_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_outputs("rst_pre", 2'b00, 2'b01, 0, 0, 1, 0, 8'h05);
    #2 reset = 1'b1;
    #1;
    check_outputs("rst_async", 2'b00, 2'b00, 0, 0, 0, 0, 8'h00);
    @(negedge clock);
    reset   = 1'b0;
    out0_in = 2'b00;
    tick();
    check_outputs("rst_idle", 2'b00, 2'b00, 0, 0, 0, 0, 8'h00);

    // start held high: done after 1+4 cycles past the RUN edge, then immediate restart.
    start   = 1'b1;
    run_len = 8'd1;
    out0_in = 2'b01;
    cyc     = 0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (done) break;
    end
    check("held done_latency", 8'(cyc), 8'd6);
    check("held signature", signature, 8'h1E);
    out0_in = 2'b00;
    tick();
    check_outputs("held restart", 2'b01, 2'b00, 0, 0, 1, 0, 8'h00);

    // Now in RUN with run_len 1 latched: a new run_len and a start pulse in DRAIN are ignored.
    start   = 1'b0;
    run_len = 8'd9;
    tick();
    check_outputs("drain0", 2'b00, 2'b00, 0, 0, 1, 0, 8'h00);
    start   = 1'b1;
    run_len = 8'd3;
    tick();
    check_outputs("drain_start", 2'b00, 2'b00, 0, 0, 1, 0, 8'h00);
    start = 1'b0;
    cyc   = 0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (done) break;
    end
    check("drain done_latency", 8'(cyc), 8'd3);
    check_outputs("drain_done", 2'b00, 2'b00, 0, 0, 0, 1, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
